// File: rtl/mem_port_arbiter.sv
// Merges the IF fetch port and the MEM load/store port onto one physical memory port.
// Data has priority; a saturating starvation counter forces a waiting fetch through.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [ADDR_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_wdata,
  input  logic [1:0]        d_byte_enable,
  output logic [ADDR_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_byte_enable,
  input  logic [ADDR_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       d_req;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  assign d_req = d_read | d_write;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (d_req && i_read && (starve_cnt == LIMIT)) begin
          state_nxt      = SERVE_I;
          starve_cnt_nxt = 4'd0;
        end else if (d_req) begin
          state_nxt = SERVE_D;
          if (i_read) starve_cnt_nxt = sat_inc(starve_cnt);
        end else if (i_read) begin
          state_nxt      = SERVE_I;
          starve_cnt_nxt = 4'd0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Responses are steered combinationally to the granted side only
  always_comb begin
    i_resp  = (state == SERVE_I) && pmem_resp;
    d_resp  = (state == SERVE_D) && pmem_resp;
    i_rdata = i_resp ? pmem_rdata : '0;
    d_rdata = d_resp ? pmem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      starve_cnt       <= 4'd0;
      pmem_addr        <= '0;
      pmem_wdata       <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= 2'b00;
      busy             <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (state == IDLE) begin
        // Grant latch: requester inputs are sampled only on the edge leaving IDLE
        if (state_nxt == SERVE_I) begin
          pmem_addr        <= i_addr;
          pmem_wdata       <= '0;
          pmem_read        <= 1'b1;
          pmem_write       <= 1'b0;
          pmem_byte_enable <= 2'b11;
          busy             <= 1'b1;
        end else if (state_nxt == SERVE_D) begin
          pmem_addr        <= d_addr;
          pmem_wdata       <= d_wdata;
          pmem_read        <= d_read & ~d_write;
          pmem_write       <= d_write;
          pmem_byte_enable <= d_byte_enable;
          busy             <= 1'b1;
        end
      end else if (pmem_resp) begin
        pmem_read  <= 1'b0;
        pmem_write <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model
// of the arbitration rules (priority, starvation count, latched grant, response steering).
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        i_read, i_resp, d_read, d_write, d_resp;
  logic [1:0]  d_byte_enable, pmem_byte_enable;
  logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;
  logic        pmem_read, pmem_write, pmem_resp, busy;

  int errors = 0;
  int checks = 0;
  int cnt    = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction starting from an IDLE cycle with requests already applied.
  task automatic serve(input int lat);
    bit          ip, dp, win_i;
    logic [15:0] ea, ew, rd;
    logic [1:0]  eb;
    logic        er, ewr;
    ip = i_read;
    dp = d_read | d_write;
    if (ip && dp && cnt == LIMIT) win_i = 1;
    else if (dp)                  win_i = 0;
    else                          win_i = 1;
    if (win_i) cnt = 0;
    else if (ip) cnt = (cnt < LIMIT) ? cnt + 1 : LIMIT;
    if (win_i) begin
      ea = i_addr; ew = 16'h0; eb = 2'b11; er = 1'b1; ewr = 1'b0;
    end else begin
      ea = d_addr; ew = d_wdata; eb = d_byte_enable; er = d_read & ~d_write; ewr = d_write;
    end
    chk("idle_busy", busy, 0);
    tick();
    chk("grant_busy", busy, 1);
    chk("grant_addr", pmem_addr, ea);
    chk("grant_read", pmem_read, er);
    chk("grant_write", pmem_write, ewr);
    chk("grant_wdata", pmem_wdata, ew);
    chk("grant_be", pmem_byte_enable, eb);
    for (int k = 0; k < lat; k++) begin
      if (win_i) i_addr = 16'($urandom);
      else begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
      chk("wait_resp", {i_resp, d_resp}, 2'b00);
      tick();
      chk("hold_addr", pmem_addr, ea);
      chk("hold_strobe", {pmem_read, pmem_write}, {er, ewr});
    end
    rd = 16'($urandom);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    chk("resp_i", i_resp, win_i);
    chk("resp_d", d_resp, !win_i);
    chk("rdata_i", i_rdata, win_i ? rd : 16'h0);
    chk("rdata_d", d_rdata, win_i ? 16'h0 : rd);
    tick();
    pmem_resp = 1'b0;
    if (win_i) i_read = 1'b0;
    else begin d_read = 1'b0; d_write = 1'b0; end
    #1;
    chk("after_busy", busy, 0);
    chk("after_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("after_resp", {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; i_addr = '0; i_read = 0; d_addr = '0; d_read = 0; d_write = 0;
    d_wdata = '0; d_byte_enable = '0; pmem_rdata = '0; pmem_resp = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_wdata_be", {pmem_wdata, pmem_byte_enable}, 18'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch only, downstream answers 3 cycles after the strobe
    i_addr = 16'h0040; i_read = 1;
    serve(3);

    // Simultaneous: data write wins, fetch follows after one IDLE cycle
    i_addr = 16'h0010; i_read = 1;
    d_addr = 16'h8000; d_write = 1; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    serve(1);
    serve(2);

    // Starvation: four data grants, then the waiting fetch, then data again
    i_addr = 16'h0ABC; i_read = 1;
    for (int k = 0; k < 5; k++) begin
      d_addr = 16'h9000 + 16'(k); d_read = 1; d_byte_enable = 2'b11; d_wdata = 16'h1111;
      serve(1);
    end
    chk("starve_d_pending", d_read, 1);
    chk("starve_i_done", i_read, 0);
    d_addr = 16'h9100;
    serve(0);

    // Read and write together behave as a write
    d_read = 1; d_write = 1; d_addr = 16'h7000; d_wdata = 16'hCAFE; d_byte_enable = 2'b10;
    serve(2);

    // Asynchronous reset in the middle of a data read
    d_read = 1; d_addr = 16'h5555; d_byte_enable = 2'b11;
    tick();
    chk("pre_rst_read", pmem_read, 1);
    tick();
    pmem_resp = 1; rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("midrst_addr", pmem_addr, 0);
    chk("midrst_be", pmem_byte_enable, 0);
    chk("midrst_resp", {i_resp, d_resp}, 2'b00);
    tick();
    pmem_resp = 0; rst_n = 1; d_read = 0; cnt = 0;
    i_read = 1; i_addr = 16'h0200;
    serve(1);

    // Stray downstream response while idle
    pmem_resp = 1;
    #1;
    chk("stray_resp", {i_resp, d_resp}, 2'b00);
    tick();
    pmem_resp = 0;
    chk("stray_busy", busy, 0);
    chk("stray_strobe", {pmem_read, pmem_write}, 2'b00);

    // Randomized traffic with held requests and random downstream latency
    for (int n = 0; n < 120; n++) begin
      if (!i_read && $urandom_range(0, 1) == 1) begin
        i_read = 1; i_addr = 16'($urandom);
      end
      if (!(d_read || d_write) && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: begin d_read = 1; d_write = 0; end
          1: begin d_read = 0; d_write = 1; end
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_byte_enable = 2'($urandom);
      end
      if (i_read || d_read || d_write) begin
        serve($urandom_range(0, 4));
      end else begin
        pmem_resp = 1'($urandom);
        #1;
        chk("rnd_idle_resp", {i_resp, d_resp}, 2'b00);
        tick();
        pmem_resp = 0;
        chk("rnd_idle_busy", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipeline datapath's two memory ports: the IF fetch port and the MEM load/store port.
- Merges both ports onto the single word-wide physical memory / L2 port.
- Data side has priority, with a bounded starvation guard for instruction fetch.
- Holds one transaction in flight at a time and routes the response only to the granted side.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits before the fetch is forced through. Legal range 1..15.
- ADDR_W, 16: address / data word width (lc3b_word).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_addr  in  ADDR_W  fetch address
- i_read  in  1  fetch request, held by requester until i_resp
- i_rdata  out  ADDR_W  fetch data, valid when i_resp=1
- i_resp  out  1  fetch completion pulse
- d_addr  in  ADDR_W  data address
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_wdata  in  ADDR_W  store data
- d_byte_enable  in  2  store byte lanes
- d_rdata  out  ADDR_W  load data, valid when d_resp=1
- d_resp  out  1  data completion pulse
- pmem_addr  out  ADDR_W  downstream address
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_wdata  out  ADDR_W  downstream write data
- pmem_byte_enable  out  2  downstream byte lanes
- pmem_rdata  in  ADDR_W  downstream read data
- pmem_resp  in  1  downstream completion
- busy  out  1  1 while in SERVE_I or SERVE_D

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. All pmem_* outputs and busy are driven from registers only.
- Reset: asynchronous; takes effect immediately, including mid-transaction.
  - State goes to IDLE and the starvation counter to 0.
  - pmem_addr, pmem_wdata, pmem_read, pmem_write, pmem_byte_enable and busy all go to 0.
  - Any in-flight transaction is abandoned; no resp is issued for it.
- IDLE arbitration, evaluated each cycle:
  - d_req = d_read | d_write.
  - If d_req and i_read and starve_cnt == STARVE_LIMIT: go to SERVE_I.
  - Else if d_req: go to SERVE_D.
  - Else if i_read: go to SERVE_I.
  - Else stay in IDLE.
- Grant latch, on the edge that leaves IDLE: latch the winner's addr / wdata / byte_enable / read / write into the pmem_* registers. pmem strobes are therefore asserted one cycle after the request is first seen in IDLE.
- Fetch grants: pmem_byte_enable = 2'b11, pmem_write = 0, pmem_wdata = 0.
- d_read and d_write both set: treated as a write. pmem_write = 1, pmem_read = 0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each SERVE_D grant while i_read = 1.
  - Clears to 0 on every SERVE_I grant.
  - Unchanged otherwise.
- In SERVE_x: pmem_* hold stable until pmem_resp. Requester inputs are not re-sampled, so changes to them mid-transaction are ignored.
- On a cycle with pmem_resp = 1 in SERVE_x:
  - x_resp = 1 combinationally and x_rdata = pmem_rdata, the same cycle.
  - Next edge: state goes to IDLE and pmem_read / pmem_write / busy clear.
- Turnaround: one IDLE cycle between transactions. Minimum back-to-back spacing is 2 cycles plus the downstream latency.
- i_resp and d_resp are never 1 in the same cycle. pmem_resp in IDLE is ignored and produces no resp.
- i_rdata / d_rdata: pmem_rdata is passed through to the granted side; the non-granted side and IDLE drive 0.
- Requester dropping its request mid-transaction: the transaction still completes and resp still pulses (requesters must hold; this is a protocol violation but must not hang the arbiter).

Test Plan:
- Fetch only: i_addr=16'h0040, i_read=1; pmem_resp 3 cycles after pmem_read rises with pmem_rdata=16'h1234 -> pmem_read rises 1 cycle after request, pmem_addr=0x0040, pmem_byte_enable=2'b11, i_resp pulses once with i_rdata=0x1234, d_resp stays 0.
- Simultaneous request: i_read at 0x0010 and d_write at 0x8000 with d_wdata=0xBEEF, be=2'b01 -> data served first (pmem_write=1, pmem_wdata=0xBEEF, pmem_byte_enable=2'b01); after d_resp, one IDLE cycle, then fetch of 0x0010 is served.
- Starvation, STARVE_LIMIT=4: i_read held while d_read is re-asserted immediately after each d_resp -> exactly 4 data transactions, then the fetch is granted, the counter clears, and data resumes afterwards.
- Read+write together: d_read=1 and d_write=1 -> pmem_write=1, pmem_read=0, single d_resp.
- Reset mid-transaction: rst_n low while in SERVE_D with pmem_read=1 -> all pmem outputs and busy go to 0 immediately, no resp; after release with i_read=1, a fetch is granted normally.
- Stray response: pmem_resp=1 for one cycle while in IDLE -> no i_resp/d_resp, state stays IDLE, counter unchanged.
